// File: rtl/trng_req_ctrl_pkg.sv
// rtl/trng_req_ctrl_pkg.sv - shared types and constants for the TRNG request controller
package trng_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WARMUP = 2'd1,
    ST_RUN    = 2'd2,
    ST_FAULT  = 2'd3
  } state_e;

endpackage

// File: rtl/trng_req_ctrl_if.sv
// rtl/trng_req_ctrl_if.sv - TRNG datapath and requester handshake bundle
interface trng_req_ctrl_if import trng_pkg::*; ();

  logic              trng_enable;
  logic              trng_enable_von;
  logic [WORD_W-1:0] trng_data;
  logic              trng_valid;
  logic [1:0]        req;
  logic [1:0]        resp_valid;
  logic [WORD_W-1:0] resp_data;

  modport master (
    output trng_enable, trng_enable_von, resp_valid, resp_data,
    input  trng_data, trng_valid, req
  );

  modport slave (
    input  trng_enable, trng_enable_von, resp_valid, resp_data,
    output trng_data, trng_valid, req
  );

endinterface

// File: rtl/trng_req_ctrl_word_fifo.sv
// rtl/trng_req_ctrl_word_fifo.sv - DEPTH x 32 synchronous word FIFO with flush
module trng_word_fifo import trng_pkg::*; #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WORD_W-1:0]        wdata,
  output logic [WORD_W-1:0]        rdata,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WORD_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_q, wr_d, rd_q, rd_d;
  logic [LW-1:0]     lvl_q, lvl_d;
  logic              do_push, do_pop;

  always_comb begin
    do_push = push && !full && !flush;
    do_pop  = pop && !empty && !flush;
    wr_d    = wr_q;
    rd_d    = rd_q;
    lvl_d   = lvl_q;
    if (flush) begin
      wr_d  = '0;
      rd_d  = '0;
      lvl_d = '0;
    end else begin
      if (do_push) wr_d = wr_q + AW'(1);
      if (do_pop)  rd_d = rd_q + AW'(1);
      if (do_push && !do_pop)      lvl_d = lvl_q + LW'(1);
      else if (do_pop && !do_push) lvl_d = lvl_q - LW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      lvl_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      lvl_q <= lvl_d;
    end
  end

  // Storage carries no reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= wdata;
  end

  assign rdata = mem_q[rd_q];
  assign level = lvl_q;
  assign full  = (lvl_q == LW'(DEPTH));
  assign empty = (lvl_q == '0);

endmodule

// File: rtl/trng_req_ctrl.sv
// rtl/trng_req_ctrl.sv - TRNG sequencer with warm-up discard, repetition health test and
// round-robin word service to two requesters
module trng_req_ctrl import trng_pkg::*; #(
  parameter int DEPTH        = 4,
  parameter int WARMUP_WORDS = 8,
  parameter int REP_LIMIT    = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   von_cfg,
  input  logic                   clear_fault,
  trng_req_ctrl_if.master        bus,
  output logic                   fault,
  output logic [1:0]             state,
  output logic [$clog2(DEPTH):0] level
);

  localparam int LW = $clog2(DEPTH) + 1;
  localparam int WW = $clog2(WARMUP_WORDS + 1);
  localparam int RW = $clog2(REP_LIMIT + 1);
  localparam logic [WW-1:0] WARM_LAST = WW'(WARMUP_WORDS - 1);
  localparam logic [RW-1:0] REP_MAX   = RW'(REP_LIMIT);

  state_e            state_q, state_d;
  logic [WW-1:0]     warm_q, warm_d;
  logic [RW-1:0]     rep_q, rep_d, rep_next;
  logic [WORD_W-1:0] prev_q, prev_d;
  logic              rr_q, rr_d;
  logic [1:0]        resp_valid_q, resp_valid_d;
  logic [WORD_W-1:0] resp_data_q, resp_data_d;
  logic              en_q, en_d;
  logic              von_q, von_d;

  logic              accept, health_fail, warm_done, fills;
  logic [1:0]        elig;
  logic              grant_any, grant_idx;
  logic              push, pop;
  logic [WORD_W-1:0] head;
  logic [LW-1:0]     fifo_level;
  logic              fifo_full, fifo_empty;

  trng_word_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst),
    .push  (push),
    .pop   (pop),
    .flush (health_fail),
    .wdata (bus.trng_data),
    .rdata (head),
    .level (fifo_level),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Health test, arbitration and FIFO control derived from current state.
  always_comb begin
    accept      = bus.trng_valid && (state_q == ST_WARMUP || state_q == ST_RUN);
    rep_next    = (bus.trng_data == prev_q) ? rep_q + RW'(1) : RW'(1);
    health_fail = accept && (rep_next >= REP_MAX);
    warm_done   = accept && (state_q == ST_WARMUP) && (warm_q == WARM_LAST);
    elig        = bus.req & ~resp_valid_q;
    grant_any   = !fifo_empty && (state_q != ST_FAULT) && !health_fail && (elig != 2'b00);
    grant_idx   = rr_q ? elig[1] : !elig[0];
    pop         = grant_any;
    push        = accept && (state_q == ST_RUN) && !health_fail;
    fills       = push && !pop && (fifo_level == LW'(DEPTH - 1));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      warm_q       <= '0;
      rep_q        <= '0;
      prev_q       <= '0;
      rr_q         <= 1'b0;
      resp_valid_q <= 2'b00;
      resp_data_q  <= '0;
      en_q         <= 1'b0;
      von_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      warm_q       <= warm_d;
      rep_q        <= rep_d;
      prev_q       <= prev_d;
      rr_q         <= rr_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      en_q         <= en_d;
      von_q        <= von_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (start && !fifo_full) state_d = ST_WARMUP;
      ST_WARMUP: if (!start) state_d = ST_IDLE;
                 else if (warm_done) state_d = ST_RUN;
      ST_RUN:    if (!start || fills) state_d = ST_IDLE;
      ST_FAULT:  if (clear_fault) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
    if (health_fail) state_d = ST_FAULT;
  end

  always_comb begin
    en_d   = (state_d == ST_WARMUP) || (state_d == ST_RUN);
    von_d  = (state_q == ST_IDLE) ? von_cfg : von_q;
    warm_d = '0;
    if (state_q == ST_WARMUP && state_d == ST_WARMUP)
      warm_d = accept ? warm_q + WW'(1) : warm_q;
    prev_d = accept ? bus.trng_data : prev_q;
    rep_d  = rep_q;
    if (accept) rep_d = health_fail ? '0 : rep_next;
    resp_valid_d = 2'b00;
    resp_data_d  = resp_data_q;
    rr_d         = rr_q;
    if (grant_any) begin
      resp_valid_d = grant_idx ? 2'b10 : 2'b01;
      resp_data_d  = head;
      rr_d         = !grant_idx;
    end
  end

  assign bus.trng_enable     = en_q;
  assign bus.trng_enable_von = von_q;
  assign bus.resp_valid      = resp_valid_q;
  assign bus.resp_data       = resp_data_q;
  assign fault               = (state_q == ST_FAULT);
  assign state               = state_q;
  assign level               = fifo_level;

endmodule
